apb_reg_completer: RTL and testbench

APB4 completer (peripheral) holding a small bank of 32-bit registers. It sits directly downstream of the APB bridge/requester and consumes its setup/access transfers. It inserts a configurable number of wait states. It signals PSLVERR for unaligned addresses, out-of-range addresses, writes to the read-only ID register, and requester protocol violations, such as PSEL dropped early.

---
 rtl/apb_reg_completer_if.sv | 31 +++
 rtl/apb_reg_completer.sv | 160 ++++++++++++++++
 tb/tb_apb_reg_completer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_reg_completer_if.sv
// APB4 bus bundle between a requester (bridge) and the register completer.
//   psel/penable/pwrite/paddr/pwdata/pstrb : requester -> completer
//   prdata/pready/pslverr                  : completer -> requester
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0) and
// continues with access cycles (psel=1, penable=1) holding paddr/pwrite
// stable until the completer returns pready=1 for exactly one cycle;
// prdata and pslverr are meaningful only in that cycle.
interface apb_reg_completer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_reg_completer.sv
// APB4 completer with a bank of NUM_REGS 32-bit registers.
// Register 0 is a read-only ID word; registers 1..NUM_REGS-1 are read/write
// with byte strobes. WAIT_STATES extra access cycles precede pready.
// Ports:
//   pclk      : clock, all state changes on the rising edge
//   presetn   : asynchronous active-low reset
//   apb       : APB4 bus (slave modport), see apb_reg_completer_if
//   dbg_state : current FSM state (0=IDLE, 1=ACCESS, 2=RESP)
// Errors (pslverr with prdata=0, no register change): unaligned address,
// index out of range, write to the ID register, requester protocol
// violation (access without setup, psel/penable dropped, paddr/pwrite
// changed during access).
module apb_reg_completer #(
    parameter int              ADDR_WIDTH  = 32,
    parameter int              DATA_WIDTH  = 32,
    parameter int              NUM_REGS    = 16,
    parameter int              WAIT_STATES = 1,
    parameter logic [31:0]     ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                   pclk,
    input  logic                   presetn,
    apb_reg_completer_if.slave     apb,
    output logic [1:0]             dbg_state
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-3:0] NUM_REGS_A = (ADDR_WIDTH-2)'(NUM_REGS);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic [ADDR_WIDTH-3:0] idx_full;
    logic [IDX_W-1:0]      idx;
    logic                  access_err;
    logic                  access_ok;
    logic                  setup_seen;
    logic [DATA_WIDTH-1:0] rd_val;

    assign idx_full   = addr_q[ADDR_WIDTH-1:2];
    assign idx        = addr_q[IDX_W+1:2];
    assign access_err = (addr_q[1:0] != 2'b00) || (idx_full >= NUM_REGS_A) ||
                        (write_q && (idx_full == '0));
    // Access cycle continues the latched transfer only if the requester
    // holds select, enable, address and direction.
    assign access_ok  = apb.psel && apb.penable &&
                        (apb.paddr == addr_q) && (apb.pwrite == write_q);
    assign setup_seen = apb.psel && !apb.penable;
    assign rd_val     = (idx == '0) ? ID_VALUE : regs_q[idx];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        // Response outputs are single-cycle: cleared unless set below.
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];

        case (state_q)
            ST_IDLE: begin
                if (setup_seen) begin
                    addr_d  = apb.paddr;
                    write_d = apb.pwrite;
                    wdata_d = apb.pwdata;
                    strb_d  = apb.pstrb;
                    cnt_d   = WAIT_INIT;
                    state_d = ST_ACCESS;
                end else if (apb.psel && apb.penable) begin
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_ACCESS: begin
                if (!access_ok) begin
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    state_d   = ST_RESP;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    pready_d = 1'b1;
                    state_d  = ST_RESP;
                    if (access_err) begin
                        pslverr_d = 1'b1;
                    end else if (write_q) begin
                        for (int k = 0; k < STRB_W; k++) begin
                            if (strb_q[k]) regs_d[idx][8*k +: 8] = wdata_q[8*k +: 8];
                        end
                    end else begin
                        prdata_d = rd_val;
                    end
                end
            end
            ST_RESP: begin
                if (setup_seen) begin
                    addr_d  = apb.paddr;
                    write_d = apb.pwrite;
                    wdata_d = apb.pwdata;
                    strb_d  = apb.pstrb;
                    cnt_d   = WAIT_INIT;
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_apb_reg_completer.sv
module tb_apb_reg_completer;
  localparam int          WAIT  = 1;
  localparam int          NREGS = 16;
  localparam logic [31:0] ID    = 32'hA9B0_0001;

  logic       pclk;
  logic       presetn;
  logic [1:0] dbg_state;

  apb_reg_completer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_reg_completer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NREGS),
    .WAIT_STATES(WAIT), .ID_VALUE(ID)
  ) dut (
    .pclk(pclk), .presetn(presetn), .apb(bus.slave), .dbg_state(dbg_state)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  // entry: {compare_data, pslverr, prdata}
  logic [33:0] exp_q[$];
  logic [31:0] model[NREGS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
  endtask

  task automatic bus_idle();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
  endtask

  // one idle cycle; response must have been a single cycle
  task automatic idle_cycle();
    bus_idle();
    @(posedge pclk); #1;
    check("idle_pready", 32'(bus.pready), 32'h0);
    check("idle_prdata", bus.prdata, 32'h0);
  endtask

  // full transfer with scoreboard; returns with the bus idle at the same
  // timestep, so a following call runs back-to-back
  task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
    logic        err;
    logic [31:0] idx;
    logic [31:0] rd;
    logic [33:0] e;
    int          n;
    idx = {2'b00, addr[31:2]};
    err = (addr[1:0] != 2'b00) || (idx >= NREGS) || (wr && idx == 0);
    rd  = 32'h0;
    if (!err && !wr) rd = (idx == 0) ? ID : model[idx];
    if (!err && wr)
      for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
    exp_q.push_back({(err || !wr), err, rd});

    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = data; bus.pstrb = strb;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    n = 0;
    while (n < 40) begin
      @(posedge pclk); #1;
      n++;
      if (bus.pready === 1'b1) break;
    end
    e = exp_q.pop_front();
    if (bus.pready !== 1'b1) begin
      check("timeout", 32'(bus.pready), 32'h1);
    end else begin
      check("latency", 32'(n), 32'(WAIT + 1));
      check("pslverr", 32'(bus.pslverr), 32'(e[32]));
      if (e[33]) check("prdata", bus.prdata, e[31:0]);
    end
    bus_idle();
  endtask

  // setup then psel dropped before the first access edge
  task automatic abort_xfer(input logic [31:0] addr, input logic [31:0] data);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = addr; bus.pwdata = data; bus.pstrb = 4'hF;
    @(posedge pclk); #1;
    bus_idle();
    @(posedge pclk); #1;
    check("abort_pready", 32'(bus.pready), 32'h1);
    check("abort_pslverr", 32'(bus.pslverr), 32'h1);
    check("abort_prdata", bus.prdata, 32'h0);
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    bus_idle();
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] a;
    int          n;
    presetn = 1'b1;
    bus_idle();
    #2;
    do_reset();
    check("rst_pready", 32'(bus.pready), 32'h0);
    check("rst_pslverr", 32'(bus.pslverr), 32'h0);
    check("rst_prdata", bus.prdata, 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);

    // 1: write then read back
    apb_xfer(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    idle_cycle();
    apb_xfer(1'b0, 32'h4, 32'h0, 4'h0);
    idle_cycle();

    // 2: byte strobes
    apb_xfer(1'b1, 32'h8, 32'hFFFFFFFF, 4'hF);
    apb_xfer(1'b1, 32'h8, 32'h12345678, 4'b0011);
    apb_xfer(1'b0, 32'h8, 32'h0, 4'h0);
    check("strb_model", model[2], 32'hFFFF5678);
    idle_cycle();

    // 3: unaligned
    apb_xfer(1'b0, 32'h3, 32'h0, 4'h0);
    apb_xfer(1'b1, 32'h5, 32'h1, 4'hF);
    apb_xfer(1'b0, 32'h4, 32'h0, 4'h0);
    idle_cycle();

    // 4: early psel drop
    abort_xfer(32'hC, 32'hAA);
    idle_cycle();
    apb_xfer(1'b0, 32'hC, 32'h0, 4'h0);
    apb_xfer(1'b0, 32'h4, 32'h0, 4'h0);
    idle_cycle();

    // 5: range / ID register
    apb_xfer(1'b0, 32'h40, 32'h0, 4'h0);
    apb_xfer(1'b1, 32'h0, 32'h1234, 4'hF);
    apb_xfer(1'b0, 32'h0, 32'h0, 4'h0);
    idle_cycle();

    // access phase with no setup
    bus.psel = 1'b1; bus.penable = 1'b1; bus.paddr = 32'h4;
    @(posedge pclk); #1;
    check("nosetup_pready", 32'(bus.pready), 32'h1);
    check("nosetup_pslverr", 32'(bus.pslverr), 32'h1);
    idle_cycle();

    // 6: reset while a read response is on the bus
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h0;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    n = 0;
    while (n < 40 && bus.pready !== 1'b1) begin
      @(posedge pclk); #1;
      n++;
    end
    check("pre_rst_prdata", bus.prdata, ID);
    presetn = 1'b0;
    #1;
    check("rst_resp_pready", 32'(bus.pready), 32'h0);
    check("rst_resp_prdata", bus.prdata, 32'h0);
    bus_idle();
    @(posedge pclk); #1 presetn = 1'b1;

    // reset mid-ACCESS of write 0x10
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'h10; bus.pwdata = 32'h55; bus.pstrb = 4'hF;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    @(posedge pclk); #3;
    check("mid_access_state", 32'(dbg_state), 32'h1);
    presetn = 1'b0;
    #1;
    check("rst_mid_pready", 32'(bus.pready), 32'h0);
    check("rst_mid_pslverr", 32'(bus.pslverr), 32'h0);
    check("rst_mid_state", 32'(dbg_state), 32'h0);
    bus_idle();
    model_reset();
    @(posedge pclk); #1 presetn = 1'b1;
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0);
    apb_xfer(1'b0, 32'h4, 32'h0, 4'h0);
    apb_xfer(1'b1, 32'h10, 32'hCAFE0001, 4'hF);
    apb_xfer(1'b1, 32'h14, 32'hCAFE0002, 4'hF);
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0);
    apb_xfer(1'b0, 32'h14, 32'h0, 4'h0);
    idle_cycle();

    // random mix
    for (int t = 0; t < 40; t++) begin
      a = 32'($urandom_range(0, 18)) * 4;
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
      apb_xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    for (int i = 0; i < NREGS; i++) apb_xfer(1'b0, 32'(i * 4), 32'h0, 4'h0);
    idle_cycle();

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
